// File: rtl/load_sequencer.sv
// rtl/load_sequencer.sv - serial frame loader for icache/dcache/frame-counter plus run launch
//
// Purpose: collects MSB-first serial frames (8 data bits then 4 address bits)
// while a frame mode is held on mode_in, then commits them for one cycle as a
// write strobe to the icache, the dcache or a frame-counter byte select.
// Mode 11 launches program execution and waits for the core to go idle.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   mode_in[1:0]    00 none, 01 icache frame, 10 dcache frame, 11 run
//   mosi_in         serial frame bit, sampled each cycle in SHIFT
//   proc_done_in    core idle indication, ends RUN
//   wr_addr_out[3:0], wr_data_out[7:0]   last committed address / data
//   icache_wen_out, dcache_wen_out, fcnt_sel_out[3:0]   one-cycle strobes
//   start_out       one-cycle launch pulse (first RUN cycle)
//   busy_out        high whenever the FSM is not IDLE
//   frame_err_out, addr_err_out   sticky errors, cleared by reset or start
//   frame_cnt_out[4:0]   committed frame count, wraps
//
// Optional feature macro: LOAD_SEQ_PARITY_EN adds a trailing even-parity bit
// to every frame; a parity mismatch is treated as a frame error.
module load_sequencer #(
  parameter int FRAME_W = 12,
  parameter int DMEM_N  = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode_in,
  input  logic       mosi_in,
  input  logic       proc_done_in,
  output logic [3:0] wr_addr_out,
  output logic [7:0] wr_data_out,
  output logic       icache_wen_out,
  output logic       dcache_wen_out,
  output logic [3:0] fcnt_sel_out,
  output logic       start_out,
  output logic       busy_out,
  output logic       frame_err_out,
  output logic       addr_err_out,
  output logic [4:0] frame_cnt_out
);

`ifdef LOAD_SEQ_PARITY_EN
  localparam int FLEN = FRAME_W + 1;
`else
  localparam int FLEN = FRAME_W;
`endif
  // Counter must hold FLEN+1 so that over-long frames stay distinguishable.
  localparam int CW = $clog2(FLEN + 2);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;
  localparam logic [1:0] RUN    = 2'd3;

  localparam logic [1:0] MODE_NONE   = 2'd0;
  localparam logic [1:0] MODE_ICACHE = 2'd1;
  localparam logic [1:0] MODE_RUN    = 2'd3;

  logic [1:0]      state;
  logic [1:0]      target;
  logic [FLEN-1:0] shift_reg;
  logic [CW-1:0]   bit_cnt;

  logic [7:0] frame_data;
  logic [3:0] frame_addr;
  logic [4:0] addr_rel;
  logic       in_dmem;
  logic       in_fsel;
  logic       frame_ok;

  // Data sits in the oldest 8 bits, address in the next 4; with parity the
  // parity bit occupies bit 0 and the fields move up by one.
  assign frame_data = shift_reg[FLEN-1 -: 8];
  assign frame_addr = shift_reg[FLEN-9 -: 4];

  // Address decode for dcache frames: data words first, then 4 byte selects.
  assign in_dmem  = ({1'b0, frame_addr} < 5'(DMEM_N));
  assign addr_rel = {1'b0, frame_addr} - 5'(DMEM_N);
  assign in_fsel  = !in_dmem && (addr_rel < 5'd4);

`ifdef LOAD_SEQ_PARITY_EN
  assign frame_ok = (bit_cnt == CW'(FLEN)) && !(^shift_reg);
`else
  assign frame_ok = (bit_cnt == CW'(FLEN));
`endif

  assign busy_out = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      target         <= MODE_NONE;
      shift_reg      <= '0;
      bit_cnt        <= '0;
      wr_addr_out    <= '0;
      wr_data_out    <= '0;
      icache_wen_out <= 1'b0;
      dcache_wen_out <= 1'b0;
      fcnt_sel_out   <= '0;
      start_out      <= 1'b0;
      frame_err_out  <= 1'b0;
      addr_err_out   <= 1'b0;
      frame_cnt_out  <= '0;
    end else begin
      // Strobes and start are single-cycle: default low every cycle.
      icache_wen_out <= 1'b0;
      dcache_wen_out <= 1'b0;
      fcnt_sel_out   <= '0;
      start_out      <= 1'b0;
      case (state)
        IDLE: begin
          if (mode_in == MODE_RUN) begin
            state         <= RUN;
            start_out     <= 1'b1;
            frame_err_out <= 1'b0;
            addr_err_out  <= 1'b0;
          end else if (mode_in != MODE_NONE) begin
            state   <= SHIFT;
            target  <= mode_in;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          if (mode_in == target) begin
            shift_reg <= {shift_reg[FLEN-2:0], mosi_in};
            if (bit_cnt != CW'(FLEN + 1)) begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end else if (mode_in == MODE_NONE && frame_ok) begin
            // Outputs are registered here so they are valid throughout COMMIT.
            state         <= COMMIT;
            wr_data_out   <= frame_data;
            wr_addr_out   <= frame_addr;
            frame_cnt_out <= frame_cnt_out + 5'd1;
            if (target == MODE_ICACHE) begin
              icache_wen_out <= 1'b1;
            end else if (in_dmem) begin
              dcache_wen_out <= 1'b1;
            end else if (in_fsel) begin
              fcnt_sel_out <= 4'b0001 << addr_rel[1:0];
            end else begin
              addr_err_out <= 1'b1;
            end
          end else begin
            // Wrong length, bad parity, or a different frame/run mode.
            state         <= IDLE;
            frame_err_out <= 1'b1;
          end
        end
        COMMIT: begin
          state <= IDLE;
        end
        RUN: begin
          if (proc_done_in && (mode_in != MODE_RUN)) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_sequencer.sv
// tb/tb_load_sequencer.sv - randomized transaction-model bench for load_sequencer
module tb_load_sequencer;
  localparam int FRAME_W = 12;
  localparam int DMEM_N  = 9;
`ifdef LOAD_SEQ_PARITY_EN
  localparam int FL = FRAME_W + 1;
`else
  localparam int FL = FRAME_W;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode_in;
  logic       mosi_in;
  logic       proc_done_in;
  logic [3:0] wr_addr_out;
  logic [7:0] wr_data_out;
  logic       icache_wen_out;
  logic       dcache_wen_out;
  logic [3:0] fcnt_sel_out;
  logic       start_out;
  logic       busy_out;
  logic       frame_err_out;
  logic       addr_err_out;
  logic [4:0] frame_cnt_out;

  always #5 clk = ~clk;

  load_sequencer #(.FRAME_W(FRAME_W), .DMEM_N(DMEM_N)) dut (
    .clk(clk), .rst(rst), .mode_in(mode_in), .mosi_in(mosi_in),
    .proc_done_in(proc_done_in), .wr_addr_out(wr_addr_out),
    .wr_data_out(wr_data_out), .icache_wen_out(icache_wen_out),
    .dcache_wen_out(dcache_wen_out), .fcnt_sel_out(fcnt_sel_out),
    .start_out(start_out), .busy_out(busy_out),
    .frame_err_out(frame_err_out), .addr_err_out(addr_err_out),
    .frame_cnt_out(frame_cnt_out)
  );

  // Transaction-level expectations: persistent values plus per-cycle pulses.
  logic [7:0] m_data;
  logic [3:0] m_addr;
  logic [4:0] m_fcnt;
  logic       m_ferr, m_aerr;
  logic       e_busy, e_start, e_iw, e_dw;
  logic [3:0] e_sel;
  bit         chk_en = 1'b0;
  int         vectors = 0;
  int         miscompares = 0;

  // DUT outputs captured just before each new input is driven.
  logic [7:0] snap_data;
  logic [3:0] snap_addr, snap_sel;
  logic [4:0] snap_fcnt;
  logic       snap_iw, snap_dw, snap_start, snap_busy, snap_ferr, snap_aerr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("wr_data_out", 32'(wr_data_out), 32'(m_data));
      check("wr_addr_out", 32'(wr_addr_out), 32'(m_addr));
      check("frame_cnt_out", 32'(frame_cnt_out), 32'(m_fcnt));
      check("frame_err_out", 32'(frame_err_out), 32'(m_ferr));
      check("addr_err_out", 32'(addr_err_out), 32'(m_aerr));
      check("busy_out", 32'(busy_out), 32'(e_busy));
      check("start_out", 32'(start_out), 32'(e_start));
      check("icache_wen_out", 32'(icache_wen_out), 32'(e_iw));
      check("dcache_wen_out", 32'(dcache_wen_out), 32'(e_dw));
      check("fcnt_sel_out", 32'(fcnt_sel_out), 32'(e_sel));
    end
  end

  task automatic cycle(input logic [1:0] md, input logic mo, input logic pd);
    @(negedge clk);
    snap_data = wr_data_out;  snap_addr = wr_addr_out;  snap_sel  = fcnt_sel_out;
    snap_fcnt = frame_cnt_out; snap_iw  = icache_wen_out; snap_dw = dcache_wen_out;
    snap_start = start_out;   snap_busy = busy_out;
    snap_ferr = frame_err_out; snap_aerr = addr_err_out;
    mode_in = md; mosi_in = mo; proc_done_in = pd;
    e_start = 1'b0; e_iw = 1'b0; e_dw = 1'b0; e_sel = 4'b0;
  endtask

  function automatic logic [FL-1:0] make_frame(input logic [7:0] d, input logic [3:0] a);
`ifdef LOAD_SEQ_PARITY_EN
    return {d, a, ^{d, a}};
`else
    return {d, a};
`endif
  endfunction

  function automatic bit parity_ok(input logic [FL-1:0] f);
`ifdef LOAD_SEQ_PARITY_EN
    return (^f) == 1'b0;
`else
    return (f === f);
`endif
  endfunction

  // One frame attempt: a setup cycle, nbits data cycles, one terminating mode,
  // then one idle cycle.
  task automatic do_frame(input logic [1:0] tgt, input int nbits,
                          input logic [FL-1:0] frame, input logic [1:0] term);
    bit ok;
    int a;
    cycle(tgt, 1'($urandom), 1'($urandom));
    e_busy = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      if (i < FL) cycle(tgt, frame[FL-1-i], 1'($urandom));
      else        cycle(tgt, 1'($urandom), 1'($urandom));
      e_busy = 1'b1;
    end
    ok = (term == 2'd0) && (nbits == FL) && parity_ok(frame);
    cycle(term, 1'($urandom), 1'($urandom));
    if (ok) begin
      e_busy = 1'b1;
      m_data = frame[FL-1 -: 8];
      m_addr = frame[FL-9 -: 4];
      m_fcnt = m_fcnt + 5'd1;
      a = int'(m_addr);
      if (tgt == 2'd1)          e_iw = 1'b1;
      else if (a < DMEM_N)      e_dw = 1'b1;
      else if (a < DMEM_N + 4)  e_sel = 4'(1 << (a - DMEM_N));
      else                      m_aerr = 1'b1;
    end else begin
      e_busy = 1'b0;
      m_ferr = 1'b1;
    end
    cycle(2'd0, 1'($urandom), 1'($urandom));
    e_busy = 1'b0;
  endtask

  task automatic do_run(input int maxc);
    logic [1:0] md;
    logic       pd;
    cycle(2'd3, 1'($urandom), 1'($urandom));
    e_busy = 1'b1; e_start = 1'b1; m_ferr = 1'b0; m_aerr = 1'b0;
    for (int i = 0; i <= maxc; i++) begin
      md = 2'($urandom); pd = 1'($urandom);
      if (i == maxc) begin md = 2'd0; pd = 1'b1; end
      cycle(md, 1'($urandom), pd);
      if (pd && md != 2'd3) begin
        e_busy = 1'b0;
        break;
      end
      e_busy = 1'b1;
    end
  endtask

  task automatic rand_valid_frame();
    logic [FL-1:0] f;
    logic [1:0]    tgt;
    f = make_frame(8'($urandom), 4'($urandom));
    tgt = ($urandom_range(0, 1) == 0) ? 2'd1 : 2'd2;
    do_frame(tgt, FL, f, 2'd0);
  endtask

  initial begin
    logic [FL-1:0] f;
    logic [1:0]    tgt, term;
    int            r;
    rst = 1'b1; mode_in = 2'd0; mosi_in = 1'b0; proc_done_in = 1'b0;
    m_data = '0; m_addr = '0; m_fcnt = '0; m_ferr = 1'b0; m_aerr = 1'b0;
    e_busy = 1'b0; e_start = 1'b0; e_iw = 1'b0; e_dw = 1'b0; e_sel = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", 32'({wr_data_out, wr_addr_out, frame_cnt_out, busy_out,
                                frame_err_out, addr_err_out, start_out}), 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    // icache frame 0xA5 / 3
    do_frame(2'd1, FL, make_frame(8'hA5, 4'h3), 2'd0);
    check("icache_strobe", 32'(snap_iw), 32'd1);
    check("icache_data", 32'(snap_data), 32'hA5);
    check("icache_addr", 32'(snap_addr), 32'd3);
    check("icache_count", 32'(snap_fcnt), 32'd1);

    // dcache data word, frame-counter select, out-of-range address
    do_frame(2'd2, FL, make_frame(8'h12, 4'h2), 2'd0);
    check("dcache_strobe", 32'({snap_dw, snap_sel}), 32'b1_0000);
    do_frame(2'd2, FL, make_frame(8'h7F, 4'hA), 2'd0);
    check("fsel_strobe", 32'({snap_dw, snap_sel}), 32'b0_0010);
    do_frame(2'd2, FL, make_frame(8'h7F, 4'hF), 2'd0);
    check("bad_addr_strobe", 32'({snap_iw, snap_dw, snap_sel}), 32'd0);
    check("bad_addr_err", 32'(snap_aerr), 32'd1);
    check("bad_addr_count", 32'(snap_fcnt), 32'd4);

    // short dcache frame
    do_frame(2'd2, 7, make_frame(8'h55, 4'h1), 2'd0);
    check("short_frame_err", 32'(snap_ferr), 32'd1);
    check("short_frame_count", 32'(snap_fcnt), 32'd4);

    // run launch, frame mode ignored, exit
    cycle(2'd3, 1'b0, 1'b0);
    e_busy = 1'b1; e_start = 1'b1; m_ferr = 1'b0; m_aerr = 1'b0;
    cycle(2'd1, 1'b1, 1'b0);
    e_busy = 1'b1;
    check("start_pulse", 32'({snap_start, snap_busy, snap_ferr, snap_aerr}), 32'b1100);
    cycle(2'd0, 1'b0, 1'b1);
    e_busy = 1'b0;
    check("run_ignores_frame", 32'({snap_start, snap_busy}), 32'b01);
    cycle(2'd0, 1'b0, 1'b0);
    e_busy = 1'b0;
    check("run_exit", 32'(snap_busy), 32'd0);

    // asynchronous reset after 6 bits of a frame
    cycle(2'd2, 1'b0, 1'b0);
    e_busy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle(2'd2, 1'b1, 1'b0);
      e_busy = 1'b1;
    end
    #2;
    chk_en = 1'b0;
    rst = 1'b1;
    #1;
    check("async_reset", 32'({wr_data_out, wr_addr_out, frame_cnt_out, busy_out, frame_err_out,
                              addr_err_out, start_out, icache_wen_out, dcache_wen_out, fcnt_sel_out}), 32'd0);
    @(negedge clk);
    rst = 1'b0; mode_in = 2'd0;
    m_data = '0; m_addr = '0; m_fcnt = '0; m_ferr = 1'b0; m_aerr = 1'b0;
    e_busy = 1'b0; e_start = 1'b0; e_iw = 1'b0; e_dw = 1'b0; e_sel = '0;
    chk_en = 1'b1;
    do_frame(2'd1, FL, make_frame(8'hC3, 4'h9), 2'd0);
    check("post_reset_commit", 32'({snap_iw, snap_data, snap_addr, snap_fcnt}),
          32'({1'b1, 8'hC3, 4'h9, 5'd1}));

    // counter wrap after 32 frames
    for (int i = 0; i < 31; i++) rand_valid_frame();
    check("count_wrap", 32'(snap_fcnt), 32'd0);

`ifdef LOAD_SEQ_PARITY_EN
    do_frame(2'd1, FL, make_frame(8'h3C, 4'h4) ^ {{(FL-1){1'b0}}, 1'b1}, 2'd0);
    check("parity_err", 32'(snap_ferr), 32'd1);
    check("parity_no_write", 32'({snap_iw, snap_fcnt}), 32'd0);
`endif

    // randomized mix of operations
    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 4) begin
        f = make_frame(8'($urandom), 4'($urandom));
`ifdef LOAD_SEQ_PARITY_EN
        if ($urandom_range(0, 7) == 0) f[0] = ~f[0];
`endif
        tgt = ($urandom_range(0, 1) == 0) ? 2'd1 : 2'd2;
        do_frame(tgt, FL, f, 2'd0);
      end else if (r <= 6) begin
        tgt = ($urandom_range(0, 1) == 0) ? 2'd1 : 2'd2;
        term = 2'($urandom);
        if (term == tgt) term = 2'd0;
        f = FL'($urandom);
        do_frame(tgt, $urandom_range(0, FL + 3), f, term);
      end else if (r <= 8) begin
        do_run($urandom_range(0, 6));
      end else begin
        for (int k = 0; k < $urandom_range(1, 3); k++) begin
          cycle(2'd0, 1'($urandom), 1'($urandom));
          e_busy = 1'b0;
        end
      end
    end
    cycle(2'd0, 1'b0, 1'b0);
    e_busy = 1'b0;
    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/load_sequencer.md
LOAD_SEQUENCER -- requirements
Module: load_sequencer

Interface
REQ-001 SHALL have parameter FRAME_W, default 12, meaning total serial frame bits: 8 data followed by 4 address.
REQ-002 SHALL have parameter DMEM_N, default 9, meaning the number of data-cache words; addresses 0..DMEM_N-1 target the dcache.
REQ-003 clk  input  1  sole clock; all flops on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 mode_in  input  2  decoded master mode: 00 none, 01 icache frame, 10 dcache frame, 11 run.
REQ-006 mosi_in  input  1  serial data, sampled every clk while a frame mode is held.
REQ-007 proc_done_in  input  1  core idle indication.
REQ-008 wr_addr_out  output  4  write address, from the frame's last 4 bits.
REQ-009 wr_data_out  output  8  write data, from the frame's first 8 bits.
REQ-010 icache_wen_out, dcache_wen_out  output  1 each  single-cycle write strobes.
REQ-011 fcnt_sel_out  output  4  one-hot frame-counter byte strobe, bit0 = byte 0.
REQ-012 start_out  output  1  single-cycle pulse launching program execution.
REQ-013 busy_out  output  1  high in any state except IDLE.
REQ-014 frame_err_out, addr_err_out  output  1 each  sticky error flags.
REQ-015 frame_cnt_out  output  5  count of committed frames, wraps 31 -> 0.

Function
REQ-016 SHALL implement FSM states IDLE, SHIFT, COMMIT, RUN.
REQ-017 IDLE: mode 01/10 -> SHIFT, latch target, clear bit counter; mode 11 -> RUN with start_out high for exactly the transition cycle; mode 00 -> stay.
REQ-018 SHIFT: each cycle mode equals latched target, shift mosi_in into LSB of a FRAME_W register (MSB-first frame), bit counter increments, saturating at FRAME_W+1.
REQ-019 SHIFT: mode becomes 00 with bit count == FRAME_W -> COMMIT; any other count -> set frame_err_out, return IDLE, no write.
REQ-020 SHIFT: mode changes to a different nonzero value -> abort as in REQ-019 (frame_err_out set), return IDLE; new mode acted on only from IDLE.
REQ-021 COMMIT lasts one cycle: wr_data_out = frame[11:4], wr_addr_out = frame[3:0], exactly one strobe asserted, frame_cnt_out increments, next state IDLE.
REQ-022 icache target: icache_wen_out for any address 0..15.
REQ-023 dcache target: addr < DMEM_N -> dcache_wen_out; DMEM_N..DMEM_N+3 -> fcnt_sel_out bit (addr-DMEM_N); higher -> no strobe, addr_err_out set, frame still counted.
REQ-024 RUN: exit to IDLE when proc_done_in==1 and mode_in!=11, sampled together; frame modes are ignored while in RUN.
REQ-025 wr_addr_out/wr_data_out SHALL hold last committed values outside COMMIT; strobes low outside COMMIT.
REQ-026 Error flags clear only on reset or on a start_out pulse.

Reset
REQ-027 rst asynchronously forces IDLE; shift register, bit counter, frame_cnt_out, wr_addr_out, wr_data_out, error flags = 0; all strobes and start_out = 0.
REQ-028 rst during SHIFT or COMMIT SHALL discard the frame with no write; a strobe cut mid-cycle is permitted.

Configuration
REQ-029 Macro LOAD_SEQ_PARITY_EN defined: frames are FRAME_W+1 bits with a trailing even-parity bit over all prior bits; a mismatch sets frame_err_out and suppresses the write and the count.
REQ-030 LOAD_SEQ_PARITY_EN undefined: no parity bit, frames exactly FRAME_W bits, no parity logic.

Verification
REQ-031 mode 01, shift 0xA5 then 0x3, drop to 00 -> one cycle later icache_wen_out=1, wr_data_out=0xA5, wr_addr_out=3, frame_cnt_out=1.
REQ-032 mode 10, frame data 0x7F addr 0xA (DMEM_N=9) -> fcnt_sel_out=0010, dcache_wen_out=0; addr 0xF -> no strobe, addr_err_out=1.
REQ-033 mode 10 for 7 bits then 00 -> frame_err_out=1, no strobe, frame_cnt_out unchanged.
REQ-034 mode 11 from IDLE -> start_out high one cycle, busy_out=1; mode 01 during RUN ignored; proc_done_in=1 with mode 00 -> IDLE next cycle.
REQ-035 rst asserted at bit 6 of a frame -> all outputs 0 immediately; subsequent complete frame commits normally.
REQ-036 32 back-to-back valid frames -> frame_cnt_out wraps to 0; with LOAD_SEQ_PARITY_EN, flipped parity bit -> frame_err_out=1, no write.
